// File: rtl/pacman_move_ctrl_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : pacman_move_ctrl_if                                         |
// | Description : Control/status bundle for the Pac-Man movement controller.  |
// |               master drives the player controls and observes the sprite;  |
// |               slave is the movement controller itself.                    |
// | Revision    : 1.0  initial release                                        |
// +---------------------------------------------------------------------------+
interface pacman_move_ctrl_if;
  logic       frame_tick;
  logic       m_up;
  logic       m_down;
  logic       m_left;
  logic       m_right;
  logic       e_start;
  logic       m_hold;
  logic [9:0] xPacLoc;
  logic [8:0] yPacLoc;
  logic [1:0] dir;
  logic       moving;

  modport master (
    output frame_tick, m_up, m_down, m_left, m_right, e_start, m_hold,
    input  xPacLoc, yPacLoc, dir, moving
  );

  modport slave (
    input  frame_tick, m_up, m_down, m_left, m_right, e_start, m_hold,
    output xPacLoc, yPacLoc, dir, moving
  );
endinterface
`default_nettype wire

// File: rtl/pacman_move_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : pacman_move_ctrl                                            |
// | Description : Moves a 3x3 Pac-Man sprite one STEP every TICKS_PER_STEP    |
// |               frame ticks in the current heading, with IDLE/RUN/HOLD      |
// |               control, start/restart and wall clamping.                   |
// | Option      : define PACMAN_WRAP_EN to make the left/right edges a tunnel |
// |               (horizontal wrap) instead of walls.                         |
// | Revision    : 1.0  initial release                                        |
// +---------------------------------------------------------------------------+
module pacman_move_ctrl #(
  parameter int X_START        = 320,
  parameter int Y_START        = 240,
  parameter int X_MIN          = 1,
  parameter int X_MAX          = 638,
  parameter int Y_MIN          = 1,
  parameter int Y_MAX          = 478,
  parameter int STEP           = 1,
  parameter int TICKS_PER_STEP = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pacman_move_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [1:0]  c_DIR_UP    = 2'd0;
  localparam logic [1:0]  c_DIR_DOWN  = 2'd1;
  localparam logic [1:0]  c_DIR_LEFT  = 2'd2;
  localparam logic [1:0]  c_DIR_RIGHT = 2'd3;

  localparam logic [9:0]  c_X_START   = 10'(X_START);
  localparam logic [8:0]  c_Y_START   = 9'(Y_START);
  localparam logic [9:0]  c_X_LO      = 10'(X_MIN);
  localparam logic [9:0]  c_X_HI      = 10'(X_MAX);
  localparam logic [8:0]  c_Y_LO      = 9'(Y_MIN);
  localparam logic [8:0]  c_Y_HI      = 9'(Y_MAX);
  // Step arithmetic is one bit wider than the coordinate so that neither
  // x-STEP nor x+STEP can wrap before the range comparison.
  localparam logic [10:0] c_STEP_X    = 11'(STEP);
  localparam logic [9:0]  c_STEP_Y    = 10'(STEP);
  localparam logic [7:0]  c_TICK_LAST = 8'(TICKS_PER_STEP - 1);

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_x,     w_x_nxt;
  logic [8:0]  r_y,     w_y_nxt;
  logic [1:0]  r_dir,   w_dir_nxt;
  logic [7:0]  r_cnt,   w_cnt_nxt;

  logic [10:0] w_x_inc, w_x_dec;
  logic [9:0]  w_y_inc, w_y_dec;
  logic [9:0]  w_x_step;
  logic [8:0]  w_y_step;
  logic        w_blocked;

  // Candidate position one step ahead in the current heading, clamped (or
  // wrapped horizontally when the tunnel option is built in).
  always_comb begin
    w_x_inc  = {1'b0, r_x} + c_STEP_X;
    w_x_dec  = {1'b0, r_x} - c_STEP_X;
    w_y_inc  = {1'b0, r_y} + c_STEP_Y;
    w_y_dec  = {1'b0, r_y} - c_STEP_Y;
    w_x_step = r_x;
    w_y_step = r_y;
    case (r_dir)
      c_DIR_UP:   w_y_step = (w_y_dec < {1'b0, c_Y_LO}) ? c_Y_LO : w_y_dec[8:0];
      c_DIR_DOWN: w_y_step = (w_y_inc > {1'b0, c_Y_HI}) ? c_Y_HI : w_y_inc[8:0];
`ifdef PACMAN_WRAP_EN
      c_DIR_LEFT: w_x_step = (w_x_dec < {1'b0, c_X_LO}) ? c_X_HI : w_x_dec[9:0];
      default:    w_x_step = (w_x_inc > {1'b0, c_X_HI}) ? c_X_LO : w_x_inc[9:0];
`else
      c_DIR_LEFT: w_x_step = (w_x_dec < {1'b0, c_X_LO}) ? c_X_LO : w_x_dec[9:0];
      default:    w_x_step = (w_x_inc > {1'b0, c_X_HI}) ? c_X_HI : w_x_inc[9:0];
`endif
    endcase
    // A clamped step that lands where we already are means a wall ahead.
    w_blocked = (w_x_step == r_x) && (w_y_step == r_y);
  end

  // Next-state, heading, tick counter and position update.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_x_nxt   = c_X_START;
        w_y_nxt   = c_Y_START;
        w_dir_nxt = c_DIR_RIGHT;
        w_cnt_nxt = 8'd0;
        if (bus.e_start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.e_start) begin
          w_x_nxt     = c_X_START;
          w_y_nxt     = c_Y_START;
          w_dir_nxt   = c_DIR_RIGHT;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ST_RUN;
        end else begin
          // The step uses the heading held before this edge; a heading
          // requested in the same cycle applies to the following step.
          if (bus.frame_tick) begin
            if (r_cnt == c_TICK_LAST) begin
              w_cnt_nxt = 8'd0;
              w_x_nxt   = w_x_step;
              w_y_nxt   = w_y_step;
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end
          if (bus.m_up)         w_dir_nxt = c_DIR_UP;
          else if (bus.m_down)  w_dir_nxt = c_DIR_DOWN;
          else if (bus.m_left)  w_dir_nxt = c_DIR_LEFT;
          else if (bus.m_right) w_dir_nxt = c_DIR_RIGHT;
          if (bus.m_hold) w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.e_start) begin
          w_x_nxt     = c_X_START;
          w_y_nxt     = c_Y_START;
          w_dir_nxt   = c_DIR_RIGHT;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ST_RUN;
        end else if (!bus.m_hold) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset parks the sprite at the start point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_x     <= c_X_START;
      r_y     <= c_Y_START;
      r_dir   <= c_DIR_RIGHT;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.xPacLoc = r_x;
  assign bus.yPacLoc = r_y;
  assign bus.dir     = r_dir;
  assign bus.moving  = (r_state == ST_RUN) && !w_blocked;

endmodule
`default_nettype wire

// File: tb/tb_pacman_move_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_pacman_move_ctrl                                         |
// | Description : Self-checking bench for pacman_move_ctrl: directed scenarios|
// |               followed by randomized play, checked every cycle against a |
// |               behavioural model of the movement rules. Honours           |
// |               PACMAN_WRAP_EN for the horizontal edge behaviour.           |
// | Revision    : 1.0  initial release                                        |
// +---------------------------------------------------------------------------+
module tb_pacman_move_ctrl;

  localparam int X_START = 320;
  localparam int Y_START = 240;
  localparam int X_MIN   = 1;
  localparam int X_MAX   = 638;
  localparam int Y_MIN   = 1;
  localparam int Y_MAX   = 478;
  localparam int STEP    = 1;
  localparam int TPS     = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pacman_move_ctrl_if u_if ();

  pacman_move_ctrl #(
    .X_START(X_START), .Y_START(Y_START),
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .STEP(STEP), .TICKS_PER_STEP(TPS)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  // Behavioural model: 0 = waiting for start, 1 = running, 2 = paused.
  int m_mode, m_x, m_y, m_dir, m_cnt;
  int n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_x = X_START; m_y = Y_START; m_dir = 3; m_cnt = 0;
  endfunction

  // Where a step from the current model position would land.
  function automatic void model_target(output int nx, output int ny);
    nx = m_x; ny = m_y;
    case (m_dir)
      0: ny = m_y - STEP;
      1: ny = m_y + STEP;
      2: nx = m_x - STEP;
      default: nx = m_x + STEP;
    endcase
`ifdef PACMAN_WRAP_EN
    if (nx > X_MAX) nx = X_MIN;
    else if (nx < X_MIN) nx = X_MAX;
`else
    if (nx > X_MAX) nx = X_MAX;
    if (nx < X_MIN) nx = X_MIN;
`endif
    if (ny > Y_MAX) ny = Y_MAX;
    if (ny < Y_MIN) ny = Y_MIN;
  endfunction

  function automatic int model_moving();
    int nx, ny;
    model_target(nx, ny);
    return (m_mode == 1 && (nx != m_x || ny != m_y)) ? 1 : 0;
  endfunction

  function automatic void model_edge(input bit ft, u, d, l, r, st, hd);
    int nx, ny;
    if (m_mode == 0) begin
      if (st) m_mode = 1;
    end else if (st) begin
      m_mode = 1; m_x = X_START; m_y = Y_START; m_dir = 3; m_cnt = 0;
    end else if (m_mode == 1) begin
      if (ft) begin
        if (m_cnt == TPS - 1) begin
          model_target(nx, ny);
          m_x = nx; m_y = ny; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      if (u)      m_dir = 0;
      else if (d) m_dir = 1;
      else if (l) m_dir = 2;
      else if (r) m_dir = 3;
      if (hd) m_mode = 2;
    end else if (!hd) begin
      m_mode = 1;
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".x"},      32'(u_if.xPacLoc), m_x);
    chk({tag, ".y"},      32'(u_if.yPacLoc), m_y);
    chk({tag, ".dir"},    32'(u_if.dir),     m_dir);
    chk({tag, ".moving"}, 32'(u_if.moving),  model_moving());
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, compare just after it.
  task automatic cyc(input bit ft, u, d, l, r, st, hd);
    u_if.frame_tick = ft; u_if.m_up = u; u_if.m_down = d;
    u_if.m_left = l; u_if.m_right = r; u_if.e_start = st; u_if.m_hold = hd;
    @(posedge clk);
    model_edge(ft, u, d, l, r, st, hd);
    #1;
    check_all("cyc");
    @(negedge clk);
  endtask

  // Reset asserted between clock edges; its effect must be immediate.
  task automatic async_reset();
    u_if.frame_tick = 1'b0; u_if.m_up = 1'b0; u_if.m_down = 1'b0;
    u_if.m_left = 1'b0; u_if.m_right = 1'b0; u_if.e_start = 1'b0;
    u_if.m_hold = 1'b0;
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("areset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit ft, st, hd;
    bit [3:0] dpat;
    n_vec = 0; n_err = 0;
    reset = 1'b1;
    u_if.frame_tick = 1'b0; u_if.m_up = 1'b0; u_if.m_down = 1'b0;
    u_if.m_left = 1'b0; u_if.m_right = 1'b0; u_if.e_start = 1'b0;
    u_if.m_hold = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Frame ticks without a start pulse leave the sprite parked.
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    chk("idle_x", 32'(u_if.xPacLoc), 320);
    chk("idle_y", 32'(u_if.yPacLoc), 240);
    chk("idle_dir", 32'(u_if.dir), 3);
    chk("idle_moving", 32'(u_if.moving), 0);

    // Start, then 8 ticks heading right: 4 steps at 2 ticks per step.
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 1, 0, 0);
    chk("run8_x", 32'(u_if.xPacLoc), 324);
    chk("run8_y", 32'(u_if.yPacLoc), 240);
    chk("run8_moving", 32'(u_if.moving), 1);

    // Drive to x=636, then 10 more steps against the right edge.
    for (int i = 0; i < 2000 && m_x != 636; i++) cyc(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 1, 0, 0);
`ifdef PACMAN_WRAP_EN
    chk("edge_x", 32'(u_if.xPacLoc), 8);
    chk("edge_moving", 32'(u_if.moving), 1);
`else
    chk("edge_x", 32'(u_if.xPacLoc), 638);
    chk("edge_moving", 32'(u_if.moving), 0);
`endif

    // Pause at x=330 with one tick already counted; counter must survive.
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 200 && m_x != 330; i++) cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1, 0, 1);
    chk("hold_x", 32'(u_if.xPacLoc), 330);
    chk("hold_moving", 32'(u_if.moving), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("resume_x", 32'(u_if.xPacLoc), 331);

    // Up beats left; the new heading drives the next step.
    cyc(0, 1, 0, 1, 0, 0, 0);
    chk("prio_dir", 32'(u_if.dir), 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("prio_y", 32'(u_if.yPacLoc), 239);

    // Run into the top wall.
    for (int i = 0; i < 1000 && m_y != Y_MIN; i++) cyc(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0, 0, 0);
    chk("top_y", 32'(u_if.yPacLoc), 1);
    chk("top_moving", 32'(u_if.moving), 0);

    // Restart from HOLD.
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("hold_start_x", 32'(u_if.xPacLoc), 320);
    chk("hold_start_y", 32'(u_if.yPacLoc), 240);
    chk("hold_start_dir", 32'(u_if.dir), 3);
    chk("hold_start_moving", 32'(u_if.moving), 1);

    // Reset in the middle of a run.
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 0, 0, 0);
    async_reset();
    chk("areset_x", 32'(u_if.xPacLoc), 320);
    chk("areset_moving", 32'(u_if.moving), 0);

    // Randomized play with sticky direction patterns.
    dpat = 4'b0001;
    hd = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 39) == 0) dpat = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) hd = ~hd;
      ft = ($urandom_range(0, 2) != 0);
      st = (m_mode == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 2499) == 0) async_reset();
      else cyc(ft, dpat[3], dpat[2], dpat[1], dpat[0], st, hd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pacman_move_ctrl.md
PACMAN_MOVE_CTRL -- requirements
Module: pacman_move_ctrl

Interface
REQ-001 The block SHALL have parameter X_START, default 320, meaning reset/restart X position.
REQ-002 The block SHALL have parameter Y_START, default 240, meaning reset/restart Y position.
REQ-003 The block SHALL have parameters X_MIN=1, X_MAX=638, Y_MIN=1, Y_MAX=478, meaning the inclusive legal centre range for the 3x3 sprite.
REQ-004 The block SHALL have parameter STEP, default 1, meaning pixels moved per step, with STEP <= X_MIN and STEP <= Y_MIN.
REQ-005 The block SHALL have parameter TICKS_PER_STEP, default 2 (range 1..255), meaning frame ticks between steps.
REQ-006 clk  in  1  single system clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 frame_tick  in  1  one-cycle pulse per video frame.
REQ-009 m_up, m_down, m_left, m_right  in  1 each  level direction requests.
REQ-010 e_start  in  1  one-cycle start/restart pulse.
REQ-011 m_hold  in  1  level pause request.
REQ-012 xPacLoc  out  10  registered sprite centre X.
REQ-013 yPacLoc  out  9  registered sprite centre Y.
REQ-014 dir  out  2  registered heading: 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT.
REQ-015 moving  out  1  combinational: 1 when state is RUN and the next step in dir is not wall-blocked.

Function
REQ-016 FSM states SHALL be IDLE, RUN, HOLD.
REQ-017 IDLE: position held at (X_START,Y_START), dir=RIGHT, tick counter=0; e_start moves to RUN next cycle.
REQ-018 RUN: m_hold=1 moves to HOLD next cycle; HOLD: m_hold=0 returns to RUN next cycle.
REQ-019 HOLD SHALL freeze position, dir and tick counter; frame_tick is ignored.
REQ-020 e_start in RUN or HOLD SHALL restart: position=(X_START,Y_START), dir=RIGHT, counter=0, state=RUN next cycle; e_start overrides m_hold and any step in that cycle.
REQ-021 In RUN, a cycle with any direction input high SHALL load dir next cycle, priority up > down > left > right; with no input high, dir SHALL be retained.
REQ-022 In RUN, each frame_tick SHALL increment the counter; when counter equals TICKS_PER_STEP-1, the counter SHALL clear and a step SHALL occur in the same edge.
REQ-023 A step SHALL use the dir register value before that edge; a direction loaded in the same cycle takes effect on the following step.
REQ-024 Step: UP y-=STEP, DOWN y+=STEP, LEFT x-=STEP, RIGHT x+=STEP; arithmetic SHALL be one bit wider than the coordinate so no underflow or overflow occurs.
REQ-025 A result beyond MIN/MAX SHALL clamp to the boundary; at the boundary the position SHALL be unchanged and moving=0.
REQ-026 TICKS_PER_STEP=1 SHALL step on every frame_tick in RUN.
REQ-027 Outputs SHALL change only on clk edges or reset; there SHALL be no latency beyond one clock from the qualifying input.

Reset
REQ-028 reset SHALL asynchronously force state=IDLE, xPacLoc=X_START, yPacLoc=Y_START, dir=RIGHT (3), counter=0, hence moving=0.
REQ-029 reset asserted mid-step or in HOLD SHALL abandon all motion; after release, the block SHALL wait in IDLE for e_start.

Configuration
REQ-030 Macro PACMAN_WRAP_EN defined: a horizontal step past X_MAX SHALL land at X_MIN, and a step past X_MIN SHALL land at X_MAX (tunnel); horizontal moving SHALL never be wall-blocked; vertical SHALL still clamp.
REQ-031 PACMAN_WRAP_EN undefined: all four edges SHALL clamp per REQ-025.

Verification
REQ-032 Reset, then 10 frame_ticks with no e_start -> xPacLoc=320, yPacLoc=240, dir=3, moving=0.
REQ-033 e_start, m_right held, 8 frame_ticks, TICKS_PER_STEP=2 -> xPacLoc=324, yPacLoc=240, moving=1.
REQ-034 Run from x=636 RIGHT for 10 steps -> without PACMAN_WRAP_EN x holds at 638 with moving=0; with it, x=638 then wraps to 1 and continues to 8.
REQ-035 RUN at (330,240), m_hold=1 for 6 frame_ticks, then release -> position unchanged in HOLD; stepping resumes with the counter value preserved.
REQ-036 m_up and m_left asserted together in RUN -> dir=0 next cycle; y decrements on the next step.
REQ-037 e_start during HOLD at (400,100) -> next cycle position=(320,240), dir=3, state RUN; reset pulse mid-RUN -> immediate (320,240), IDLE.
